// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the multiply/divide sequencer.
package muldiv_pkg;
  localparam int CNT_W           = 6;
  localparam int MULT_CYCLES_DEF = 32;
  localparam int DIV_CYCLES_DEF  = 32;

  typedef enum logic [1:0] {IDLE, RUN, WB, DIVZ} state_t;
  typedef enum logic       {OP_MULT, OP_DIV}     op_t;
endpackage

// File: rtl/muldiv_cycle_cnt.sv
// Loadable down-counter tracking the remaining iterations of the active unit.
// It stops at zero instead of wrapping; every accept reloads it.
module muldiv_cycle_cnt
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             one
);
  logic [CNT_W-1:0] cnt;

  // Load on accept, otherwise count down while enabled and non-zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (en && cnt != '0)    cnt <= cnt - CNT_W'(1);
  end

  assign one = (cnt == CNT_W'(1));
endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between the control unit and the iterative mult/div datapaths:
// captures operands, pulses the selected unit's start, waits out its
// iterations, then commits the unit's hi/lo into the architectural HI/LO.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic        abort,
  input  logic        hilo_rd,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        mult_start,
  output logic        div_start,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0_exc,
  output logic        stall
);
  state_t           state;
  op_t              op_sel;
  logic             done_q;
  logic             accept;
  logic             cnt_one;
  logic [CNT_W-1:0] load_val;

  // A start only counts in IDLE; MULT has priority, and DIV by zero never
  // reaches the divider so it does not load the counter.
  assign accept   = (state == IDLE) && (start_mult || (start_div && b != '0));
  assign load_val = start_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

  muldiv_cycle_cnt u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .en       (state == RUN),
    .load_val (load_val),
    .one      (cnt_one)
  );

  // Main sequencer; all outputs registered, pulses default low each edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      op_sel     <= OP_MULT;
      op_a       <= '0;
      op_b       <= '0;
      hi         <= '0;
      lo         <= '0;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      busy       <= 1'b0;
      done_q     <= 1'b0;
      div0_exc   <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      done_q     <= 1'b0;
      div0_exc   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult) begin
            op_a       <= a;
            op_b       <= b;
            op_sel     <= OP_MULT;
            mult_start <= 1'b1;
            busy       <= 1'b1;
            state      <= RUN;
          end else if (start_div) begin
            busy <= 1'b1;
            if (b == '0) begin
              div0_exc <= 1'b1;
              state    <= DIVZ;
            end else begin
              op_a      <= a;
              op_b      <= b;
              op_sel    <= OP_DIV;
              div_start <= 1'b1;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt_one) begin
            done_q <= 1'b1;
            state  <= WB;
          end
        end
        WB: begin
          if (!abort) begin
            hi <= (op_sel == OP_MULT) ? mult_hi : div_hi;
            lo <= (op_sel == OP_MULT) ? mult_lo : div_lo;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        DIVZ: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush landing in the write-back cycle cancels the commit, so the
  // done pulse is withdrawn along with it.
  assign done  = done_q & ~abort;
  assign stall = hilo_rd & busy;
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer that sits between the main control unit and the iterative multiply/divide datapaths. It accepts MULT/DIV issue requests, captures the operands, and fires a one-cycle start pulse into the selected unit. It then counts the unit's iteration cycles, writes the unit's hi/lo result into the architectural HI/LO registers, and reports busy/done. It also produces the stall condition for MFHI/MFLO issued while an operation is in flight.

## Interface
- MULT_CYCLES, 32: iterations the multiplier needs after its start pulse.
- DIV_CYCLES, 32: iterations the divider needs after its start pulse.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start_mult  in  1  issue MULT; sampled only in IDLE.
- start_div  in  1  issue DIV; sampled only in IDLE.
- abort  in  1  pipeline flush; cancels an in-flight operation.
- hilo_rd  in  1  control unit wants to read HI/LO this cycle.
- a, b  in  32 each  operands, captured on an accepted start.
- mult_hi, mult_lo  in  32 each  multiplier result.
- div_hi, div_lo  in  32 each  divider result (remainder, quotient).
- op_a, op_b  out  32 each  captured operands driven to both units.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- div_start  out  1  one-cycle start pulse to the divider.
- hi, lo  out  32 each  architectural HI/LO registers.
- busy  out  1  operation in flight; new starts are ignored.
- done  out  1  one-cycle pulse in the HI/LO write cycle.
- div0_exc  out  1  one-cycle pulse on a DIV with b == 0.
- stall  out  1  equals hilo_rd & busy (combinational).

## Operation
- States:
  - IDLE: accepts starts.
  - RUN: counting the unit's iterations.
  - WB: writes HI/LO.
  - DIVZ: signals divide-by-zero.
- Op select register: MULT or DIV, chosen at accept.
- IDLE, start_mult=1 → capture a/b into op_a/op_b, select MULT, load counter with MULT_CYCLES, go to RUN.
- IDLE, start_div=1 with b≠0 → same, selecting DIV and loading DIV_CYCLES.
- IDLE, start_div=1 with b==0 → go to DIVZ. No unit start, HI/LO unchanged.
- start_mult and start_div both high → MULT wins; the DIV request is dropped.
- Starts while not in IDLE are ignored; the control unit gates issue with busy.
- RUN:
  - The first RUN cycle drives mult_start or div_start per the op select.
  - The counter decrements every edge.
  - Counter at 1 → go to WB on the next edge.
- WB: HI/LO loaded from the selected unit's outputs, done=1, then back to IDLE.
- DIVZ: div0_exc=1 for one cycle, then back to IDLE.
- abort=1 in RUN or WB → IDLE on the next edge; no HI/LO write and no done. abort is ignored in IDLE and DIVZ.
- Arithmetic: the counter is 6-bit unsigned and never wraps (it is reloaded on every accept). The controller never modifies result data.

## Timing
- Reset values:
  - hi, lo, op_a, op_b = 0.
  - mult_start, div_start, busy, done, div0_exc = 0.
  - State = IDLE, counter = 0.
- Start accepted at edge E0 → start pulse high during the cycle after E0; the unit samples it at E1.
- MULT: RUN occupies the cycles E0..E32, WB is the cycle E32..E33, and HI/LO are visible after E33. Start-to-done latency is 33 cycles.
- DIV: the same shape using DIV_CYCLES.
- busy is high in RUN, WB and DIVZ; its first high cycle follows E0.
- A new start is accepted at the earliest on the edge ending WB+1, i.e. back-to-back with one IDLE cycle.
- op_a/op_b hold stable from acceptance until the next accept.
- reset assertion mid-RUN: outputs clear immediately; any partial result is discarded.

## Structure
- Package muldiv_pkg holds:
  - the state enum (IDLE, RUN, WB, DIVZ);
  - the op-select enum (OP_MULT, OP_DIV);
  - CNT_W = 6 and the default cycle counts.
- Sub-module muldiv_cycle_cnt: loadable 6-bit down-counter with async active-low reset, a load value input and a count==1 flag.
- The multiplier and divider are instantiated at the top level, not inside this block.

## Test plan
- MULT a=7, b=0xFFFFFFFD (−3), with the real multiplier attached → mult_start high during cycle 1 only, done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high for cycles 1–33.
- DIV a=100, b=0 → div0_exc pulses in cycle 1, no div_start, no done, HI/LO keep their previous values (0x0/0x2A preloaded).
- start_mult and start_div asserted together (a=5, b=6) → only mult_start fires, lo=30 at done; start_mult re-asserted at cycle 10 → ignored, a single done.
- MULT issued, abort at cycle 15 → no done, HI/LO unchanged, busy low from cycle 16, and a new MULT accepted in cycle 16.
- hilo_rd held high through a MULT → stall follows busy exactly (cycles 1–33) and drops in the cycle where HI/LO hold the new values.
- reset pulled low at cycle 20 of a DIV → all outputs zero asynchronously; after release, state is IDLE and a DIV 100/7 completes with lo=14, hi=2.
